// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack data-memory bus, write-back pulse, timeout abort.
// Define MEM_SUBWORD_EN for byte/halfword loads and stores decoded from funct3.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       alu_out_i,
    input  logic [31:0]       store_data_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              valid_o,
    output logic [31:0]       wb_data_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_n;

    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wb_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic              err_q;

    logic              is_mem;
    logic              fault;
    logic              timeout;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       ld_data;

    assign is_mem  = mem_read_i | mem_write_i;
    assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1);

`ifdef MEM_SUBWORD_EN
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        bad;
    logic        mis;
    logic [31:0] sh;

    always_comb begin
        bad     = 1'b0;
        mis     = 1'b0;
        be_c    = 4'b1111;
        wdata_c = store_data_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_out_i[1:0];
                wdata_c = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                mis     = alu_out_i[0];
                be_c    = alu_out_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data_i[15:0]}};
            end
            2'b10:   mis = alu_out_i[1:0] != 2'b00;
            default: bad = 1'b1;
        endcase
        // Unsigned variants exist only for loads, and only below word size.
        if (funct3_i[2] && (!mem_read_i || funct3_i[1]))
            bad = 1'b1;
    end

    assign fault = is_mem & (bad | mis);

    always_comb begin
        sh = dmem_rdata_i >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld_data = {24'b0, sh[7:0]};
            3'b101:  ld_data = {16'b0, sh[15:0]};
            default: ld_data = sh;
        endcase
    end
`else
    logic unused_f3;

    assign unused_f3 = ^funct3_i;
    assign fault     = is_mem & (alu_out_i[1:0] != 2'b00);
    assign be_c      = 4'b1111;
    assign wdata_c   = store_data_i;
    assign ld_data   = dmem_rdata_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        dmem_req_o = 1'b0;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i)
                    state_n = (is_mem && !fault) ? REQ : RESP;
            end
            REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i || timeout)
                    state_n = RESP;
            end
            RESP: begin
                valid_o = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wb_q    <= '0;
            err_q   <= 1'b0;
`ifdef MEM_SUBWORD_EN
            off_q   <= '0;
            f3_q    <= '0;
`endif
        end else begin
            unique case (1'b1)
                state == IDLE && valid_i: begin
                    cnt <= '0;
                    if (!is_mem) begin
                        wb_q  <= alu_out_i;
                        err_q <= 1'b0;
                    end else if (fault) begin
                        wb_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        addr_q  <= {alu_out_i[ADDR_W-1:2], 2'b00};
                        wdata_q <= wdata_c;
                        be_q    <= be_c;
                        // Read+write together is treated as a load.
                        we_q    <= mem_write_i & ~mem_read_i;
`ifdef MEM_SUBWORD_EN
                        off_q   <= alu_out_i[1:0];
                        f3_q    <= funct3_i;
`endif
                    end
                end
                state == REQ: begin
                    cnt <= cnt + 8'd1;
                    if (dmem_ack_i) begin
                        wb_q  <= we_q ? '0 : ld_data;
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        wb_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_data_o    = wb_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// transactions checked against a byte-lane access model.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] alu_out_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'b010;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        valid_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int errs = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .alu_out_i(alu_out_i), .store_data_i(store_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input bit rd, input bit wr,
        input logic [31:0] a, input logic [31:0] sd,
        input logic [31:0] rdat, input logic [2:0] f3,
        output bit req, output logic [3:0] be, output logic [31:0] wd,
        output logic [31:0] wb, output bit err);
        int sz;
        int off;
        bit sgn;
        bit ok;
        logic [31:0] mask;
        req = 0;
        be  = '0;
        wd  = sd;
        wb  = '0;
        err = 0;
        if (!rd && !wr) begin
            wb = a;
            return;
        end
`ifdef MEM_SUBWORD_EN
        ok  = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                 : (f3 inside {3'd0, 3'd1, 3'd2});
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sgn = !f3[2];
`else
        ok  = 1;
        sz  = 4;
        sgn = 0;
`endif
        off = int'(a % 32'd4);
        if (!ok || (off % sz) != 0) begin
            err = 1;
            return;
        end
        req  = 1;
        mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        be   = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      wd = {24'b0, sd[7:0]} * 32'h0101_0101;
        else if (sz == 2) wd = {16'b0, sd[15:0]} * 32'h0001_0001;
        else              wd = sd;
        if (rd) begin
            wb = (rdat >> (8 * off)) & mask;
            if (sgn && sz < 4 && wb[8 * sz - 1]) wb = wb | ~mask;
        end
    endfunction

    // dly = REQ cycle on which ack is driven; outside 1..TO means never.
    task automatic do_xact(input bit rd, input bit wr,
            input logic [31:0] a, input logic [31:0] sd,
            input logic [31:0] rdat, input logic [2:0] f3,
            input int dly, input string tag);
        bit ereq;
        bit eerr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] ewb;
        int n;
        bit st;
        model(rd, wr, a, sd, rdat, f3, ereq, ebe, ewd, ewb, eerr);
        st = wr && !rd;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errs++;
            $display("FAIL %s.ready: got %b want 1", tag, ready_o);
        end
        valid_i = 1; alu_out_i = a; store_data_i = sd;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        @(posedge clk); #1;
        valid_i = 0; mem_read_i = 0; mem_write_i = 0;
        store_data_i = $urandom;
        if (ereq) begin
            checks++;
            if (dmem_we_o !== st || dmem_be_o !== ebe ||
                dmem_addr_o !== {a[31:2], 2'b00} ||
                (st && dmem_wdata_o !== ewd)) begin
                errs++;
                $display("FAIL %s.bus: got we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h wd=%h",
                         tag, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
                         st, ebe, {a[31:2], 2'b00}, ewd);
            end
            for (int c = 1; c <= TO; c++) begin
                checks++;
                if (dmem_req_o !== 1'b1 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL %s.req_held: cycle %0d got req=%b rdy=%b vld=%b want 1 0 0",
                             tag, c, dmem_req_o, ready_o, valid_o);
                end
                if (c == dly) begin
                    dmem_ack_i = 1; dmem_rdata_i = rdat;
                end else begin
                    dmem_rdata_i = $urandom;
                end
                @(posedge clk); #1;
                dmem_ack_i = 0;
                if (c == dly) break;
            end
            if (dly < 1 || dly > TO) begin
                eerr = 1; ewb = '0;
            end
        end
        checks++;
        if (valid_o !== 1'b1 || dmem_req_o !== 1'b0 || ready_o !== 1'b0 ||
            err_o !== eerr || wb_data_o !== ewb) begin
            errs++;
            $display("FAIL %s.resp: got v=%b req=%b rdy=%b err=%b wb=%h want 1 0 0 %b %h",
                     tag, valid_o, dmem_req_o, ready_o, err_o, wb_data_o, eerr, ewb);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || err_o !== eerr || wb_data_o !== ewb) begin
            errs++;
            $display("FAIL %s.hold: got v=%b rdy=%b err=%b wb=%h want 0 1 %b %h",
                     tag, valid_o, ready_o, err_o, wb_data_o, eerr, ewb);
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || dmem_req_o !== 1'b0 ||
            dmem_we_o !== 1'b0 || dmem_be_o !== 4'b0 || dmem_addr_o !== 32'b0 ||
            dmem_wdata_o !== 32'b0 || wb_data_o !== 32'b0 || err_o !== 1'b0) begin
            errs++;
            $display("FAIL reset: got rdy=%b v=%b req=%b we=%b be=%b addr=%h wd=%h wb=%h err=%b want 1 and zeros",
                     ready_o, valid_o, dmem_req_o, dmem_we_o, dmem_be_o,
                     dmem_addr_o, dmem_wdata_o, wb_data_o, err_o);
        end
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_pass;
        do_xact(0, 0, 32'h1234, 32'h0, 32'h0, 3'b010, 1, "alu_pass");
        do_xact(0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b111, 1, "alu_ones");
    endtask

    task automatic test_load;
        do_xact(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3'b010, 3, "lw");
        do_xact(1, 0, 32'h200, 32'h0, 32'h1357_9BDF, 3'b010, 1, "lw_fast");
        do_xact(1, 1, 32'h300, 32'h5555_AAAA, 32'hCAFE_F00D, 3'b010, 2, "rd_wr_both");
    endtask

    task automatic test_store;
        do_xact(0, 1, 32'h104, 32'hA5A5_A5A5, 32'h0, 3'b010, 2, "sw");
    endtask

    task automatic test_misaligned;
        do_xact(1, 0, 32'h102, 32'h0, 32'h0, 3'b010, 1, "lw_mis");
        do_xact(0, 1, 32'h101, 32'h1111_2222, 32'h0, 3'b010, 1, "sw_mis");
    endtask

    task automatic test_timeout;
        do_xact(1, 0, 32'h108, 32'h0, 32'h0, 3'b010, 0, "lw_timeout");
        dmem_ack_i = 1; dmem_rdata_i = 32'h7777_7777;
        @(posedge clk); #1;
        dmem_ack_i = 0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || dmem_req_o !== 1'b0 ||
            err_o !== 1'b1 || wb_data_o !== 32'h0) begin
            errs++;
            $display("FAIL late_ack: got v=%b rdy=%b req=%b err=%b wb=%h want 0 1 0 1 0",
                     valid_o, ready_o, dmem_req_o, err_o, wb_data_o);
        end
        do_xact(1, 0, 32'h10C, 32'h0, 32'h2468_ACE0, 3'b010, TO, "ack_at_limit");
    endtask

    task automatic test_reset_mid;
        valid_i = 1; alu_out_i = 32'h400; mem_read_i = 1; funct3_i = 3'b010;
        @(posedge clk); #1;
        valid_i = 0; mem_read_i = 0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req_o !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid.req: got %b want 1", dmem_req_o);
        end
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req_o !== 1'b0 || ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid.after: got req=%b rdy=%b v=%b want 0 1 0",
                     dmem_req_o, ready_o, valid_o);
        end
        rst = 1;
        dmem_ack_i = 1; dmem_rdata_i = 32'h9999_9999;
        @(posedge clk); #1;
        dmem_ack_i = 0;
        repeat (2) begin
            checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1 || wb_data_o !== 32'h0) begin
                errs++;
                $display("FAIL rst_mid.late_ack: got v=%b rdy=%b wb=%h want 0 1 0",
                         valid_o, ready_o, wb_data_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_subword;
`ifdef MEM_SUBWORD_EN
        do_xact(1, 0, 32'h103, 32'h0, 32'h8012_3456, 3'b100, 1, "lbu");
        do_xact(1, 0, 32'h103, 32'h0, 32'h8012_3456, 3'b000, 2, "lb");
        do_xact(1, 0, 32'h102, 32'h0, 32'h9ABC_1234, 3'b001, 1, "lh");
        do_xact(0, 1, 32'h101, 32'h0000_00C3, 32'h0, 3'b000, 1, "sb");
        do_xact(0, 1, 32'h102, 32'h0000_BEEF, 32'h0, 3'b001, 1, "sh");
        do_xact(1, 0, 32'h101, 32'h0, 32'h0, 3'b001, 1, "lh_mis");
        do_xact(0, 1, 32'h100, 32'h0, 32'h0, 3'b100, 1, "bad_f3");
`endif
    endtask

    task automatic test_random;
        bit rd;
        bit wr;
        logic [31:0] a;
        int sel;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 3);
            rd  = (sel == 1) || (sel == 3);
            wr  = (sel == 2) || (sel == 3);
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            do_xact(rd, wr, a, $urandom, $urandom, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 6), "random");
        end
    endtask

    initial begin
        test_reset;
        test_alu_pass;
        test_load;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_subword;
        test_random;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1);
    end
endmodule
